// File: rtl/uart_pkg.sv
// Shared types for the UART echo controller.
// FSM state encodings and the default data width.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_READ,
    RX_CLR
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_WRITE,
    TX_ACK,
    TX_BUSY
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered read port.
// dout is loaded from the head entry on the pop edge.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [DATA_W-1:0]      din,
  input  logic                   pop,
  output logic [DATA_W-1:0]      dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      dout   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        dout   <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  a_no_push_full: assert property (
    @(posedge clk) disable iff (rst) !(push && full)
  );

  a_no_pop_empty: assert property (
    @(posedge clk) disable iff (rst) !(pop && empty)
  );

endmodule

// File: rtl/uart_echo_ctrl.sv
// Echo master for the CoreUART parallel port.
// Reads bytes via oen, buffers them, writes them back via wen.
module uart_echo_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_W     = UART_DATA_W,
  parameter int FIFO_DEPTH = 16,
  parameter int TX_ACK_MAX = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rxrdy,
  input  logic [DATA_W-1:0]           data_out,
  output logic                        oen,
  input  logic                        txrdy,
  output logic                        wen,
  output logic [DATA_W-1:0]           data_in,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [15:0]                 rx_cnt,
  output logic [15:0]                 tx_cnt,
  output logic                        tx_timeout
);

  localparam int AKW = (TX_ACK_MAX > 1) ? $clog2(TX_ACK_MAX) : 1;

  rx_state_t         rx_state;
  rx_state_t         rx_next;
  tx_state_t         tx_state;
  tx_state_t         tx_next;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic              ack_last;
  logic              to_set;
  logic [AKW-1:0]    ack_cnt;
  logic [DATA_W-1:0] fifo_dout;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (data_out),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  assign ack_last = (ack_cnt == AKW'(TX_ACK_MAX - 1));

  always_comb begin
    rx_next = rx_state;
    push    = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rxrdy && !full) begin
          rx_next = RX_READ;
        end
      end
      RX_READ: begin
        push    = 1'b1;
        rx_next = RX_CLR;
      end
      RX_CLR: begin
        if (!rxrdy) begin
          rx_next = RX_IDLE;
        end
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      oen      <= 1'b1;
      rx_cnt   <= '0;
    end else begin
      rx_state <= rx_next;
      oen      <= (rx_next != RX_READ);
      if (push) begin
        rx_cnt <= rx_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    tx_next = tx_state;
    pop     = 1'b0;
    to_set  = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (!empty && txrdy) begin
          pop     = 1'b1;
          tx_next = TX_WRITE;
        end
      end
      TX_WRITE: tx_next = TX_ACK;
      TX_ACK: begin
        if (!txrdy) begin
          tx_next = TX_BUSY;
        end else if (ack_last) begin
          to_set  = 1'b1;
          tx_next = TX_IDLE;
        end
      end
      TX_BUSY: begin
        if (txrdy) begin
          tx_next = TX_IDLE;
        end
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  // The FIFO read lands during WRITE, so data_in and the
  // wen strobe are registered out of WRITE together.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state   <= TX_IDLE;
      wen        <= 1'b1;
      data_in    <= '0;
      tx_cnt     <= '0;
      ack_cnt    <= '0;
      tx_timeout <= 1'b0;
    end else begin
      tx_state <= tx_next;
      wen      <= (tx_state != TX_WRITE);
      if (tx_state == TX_WRITE) begin
        data_in <= fifo_dout;
        tx_cnt  <= tx_cnt + 16'd1;
        ack_cnt <= '0;
      end else if (tx_state == TX_ACK) begin
        ack_cnt <= ack_cnt + 1'b1;
      end
      if (to_set) begin
        tx_timeout <= 1'b1;
      end
    end
  end

endmodule
